// File: rtl/gate_sweeper.sv
// Truth-table sequencer for a 2-input gate: steps {a,b} through 00..11, holds each
// vector SETTLE cycles, samples q against a latched expected table, reports mask/pass.
module gate_sweeper #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] expected,
  input  logic       q,
  output logic       a,
  output logic       b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_mask
);

  localparam int unsigned CW = (SETTLE + 1 > 1) ? $clog2(SETTLE + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0]    exp_q, exp_n;
  logic [3:0]    mask_q, mask_n;
  logic          pass_q, pass_n;
  logic          done_q, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      cnt    <= '0;
      exp_q  <= '0;
      mask_q <= '0;
      pass_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      cnt    <= cnt_n;
      exp_q  <= exp_n;
      mask_q <= mask_n;
      pass_q <= pass_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cnt_n   = cnt;
    exp_n   = exp_q;
    mask_n  = mask_q;
    pass_n  = pass_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          idx_n   = '0;
          cnt_n   = '0;
          exp_n   = expected;
          mask_n  = '0;
          pass_n  = 1'b0;
        end
      end
      RUN: begin
        if (cnt == CNT_LAST) begin
          mask_n[idx] = q ^ exp_q[idx];
          cnt_n       = '0;
          if (idx == 2'd3) begin
            // pass must include the compare made on this final sample edge
            state_n = IDLE;
            done_n  = 1'b1;
            pass_n  = (mask_n == '0);
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign a         = idx[1];
  assign b         = idx[0];
  assign busy      = (state == RUN);
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = mask_q;

endmodule
